// File: rtl/eater_disp_pkg.sv
// Shared types and constants for the output-register display driver:
// conversion FSM states, segment patterns and digit scan indices.
package eater_disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;

  // Entry d holds the pattern for decimal digit d; entry 9 is listed first.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  localparam logic [1:0] ONES     = 2'd0;
  localparam logic [1:0] TENS     = 2'd1;
  localparam logic [1:0] HUNDREDS = 2'd2;
  localparam logic [1:0] SIGN     = 2'd3;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder with a blanking input.
module seg7_decode
  import eater_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    if (blank_i || (bcd_i > 4'd9)) begin
      seg_o = SEG_BLANK;
    end else begin
      seg_o = SEG_TABLE[bcd_i];
    end
  end

endmodule

// File: rtl/out_display_driver.sv
// Captures the output-register byte, converts it to decimal with a sequential
// double-dabble, and scans sign/hundreds/tens/ones onto a multiplexed display.
module out_display_driver
  import eater_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic       fastClk,
  input  logic       rst,
  input  logic       out_valid,
  input  logic [7:0] out_data,
  input  logic       signed_mode,
  output logic [6:0] seg,
  output logic [3:0] digit_sel,
  output logic       busy
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  state_e            state_q, state_d;
  logic [7:0]        mag_q, mag_d;
  logic [11:0]       bcd_q, bcd_d, bcd_adj;
  logic [3:0]        iter_q, iter_d;
  logic              conv_neg_q, conv_neg_d;
  logic [3:0]        hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        digit_sel_q, digit_sel_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        dec_bcd;
  logic              dec_blank;
  logic [6:0]        dec_seg;

  // Conversion FSM and display registers. Display registers move only on the
  // commit edge, so partial BCD never reaches the segments.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d    = state_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    conv_neg_d = conv_neg_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    neg_d      = neg_q;

    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end

    if (state_q == CONV) begin
      if (iter_q == 4'd8) begin
        hund_d  = bcd_q[11:8];
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        neg_d   = conv_neg_q;
        state_d = IDLE;
      end else begin
        bcd_d  = {bcd_adj[10:0], mag_q[7]};
        mag_d  = {mag_q[6:0], 1'b0};
        iter_d = iter_q + 4'd1;
      end
    end

    // A new strobe always restarts the conversion; on the commit edge the old
    // result has already been committed above.
    if (out_valid) begin
      if (signed_mode && out_data[7]) begin
        conv_neg_d = 1'b1;
        mag_d      = ~out_data + 8'd1;
      end else begin
        conv_neg_d = 1'b0;
        mag_d      = out_data;
      end
      bcd_d   = '0;
      iter_d  = '0;
      state_d = CONV;
    end
  end

  // Digit scan; segment data is taken from next-state display values so that
  // seg and digit_sel update together.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    digit_sel_d = 4'b0001 << idx_d;

    dec_bcd   = ones_d;
    dec_blank = 1'b0;
    case (idx_d)
      TENS: begin
        dec_bcd   = tens_d;
        dec_blank = (hund_d == 4'd0) && (tens_d == 4'd0);
      end
      HUNDREDS: begin
        dec_bcd   = hund_d;
        dec_blank = (hund_d == 4'd0);
      end
      default: ;
    endcase

    seg_d = (idx_d == SIGN) ? (neg_d ? SEG_MINUS : SEG_BLANK) : dec_seg;
  end

  seg7_decode u_dec (
    .bcd_i   (dec_bcd),
    .blank_i (dec_blank),
    .seg_o   (dec_seg)
  );

  always_ff @(posedge fastClk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      conv_neg_q  <= 1'b0;
      hund_q      <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= ONES;
      digit_sel_q <= 4'b0001;
      seg_q       <= SEG_TABLE[0];
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      conv_neg_q  <= conv_neg_d;
      hund_q      <= hund_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = digit_sel_q;
  assign busy      = (state_q == CONV);

endmodule
